// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU control sequencer.
// Opcode map, phase states and the control strobe bundle.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P0   = 4'd1,
    S_P1   = 4'd2,
    S_P2   = 4'd3,
    S_P3   = 4'd4,
    S_P4   = 4'd5,
    S_P5   = 4'd6,
    S_P6   = 4'd7,
    S_P7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
    logic illegal;
  } ctl_t;

  typedef struct packed {
    logic alu;
    logic sto;
    logic jmp;
    logic skz;
    logic hlt;
    logic ill;
  } op_cls_t;

  // Strobes for the phase being entered, given the decoded op.
  function automatic ctl_t phase_ctl(
    input logic [2:0] ph,
    input op_cls_t    c,
    input logic       zero
  );
    ctl_t o;
    o = '0;
    unique case (ph)
      3'd0: begin
        o.rd      = 1'b1;
        o.load_ir = 1'b1;
      end
      3'd1: begin
        o.inc_pc  = 1'b1;
        o.rd      = 1'b1;
        o.load_ir = 1'b1;
      end
      3'd2: o = '0;
      3'd3: begin
        o.inc_pc  = 1'b1;
        o.halt    = c.hlt;
        o.illegal = c.ill;
      end
      3'd4: begin
        o.load_pc     = c.jmp;
        o.rd          = c.alu;
        o.datactl_ena = c.sto;
      end
      3'd5: begin
        o.load_acc    = c.alu;
        o.rd          = c.alu;
        o.inc_pc      = (c.skz & zero) | c.jmp;
        o.load_pc     = c.jmp;
        o.wr          = c.sto;
        o.datactl_ena = c.sto;
      end
      3'd6: begin
        o.datactl_ena = c.sto;
        o.load_acc    = c.alu;
        o.rd          = c.alu;
      end
      3'd7: o.inc_pc = c.skz & zero;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_ctl_decode.sv
// Opcode classifier for the control sequencer.
// Any nonzero extension bit marks the opcode illegal.
module cpu_ctl_decode #(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] opcode,
  output logic           alu,
  output logic           sto,
  output logic           jmp,
  output logic           skz,
  output logic           hlt,
  output logic           ill
);
  import cpu_pkg::*;

  logic [2:0] base;

  assign base = opcode[2:0];
  assign ill  = |(opcode >> 3);

  always_comb begin
    alu = 1'b0;
    sto = 1'b0;
    jmp = 1'b0;
    skz = 1'b0;
    hlt = 1'b0;
    unique case (base)
      OP_HLT: hlt = !ill;
      OP_SKZ: skz = !ill;
      OP_ADD,
      OP_AND,
      OP_XOR,
      OP_LDA: alu = !ill;
      OP_STO: sto = !ill;
      OP_JMP: jmp = !ill;
      default: alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctl_seq.sv
// Eight-phase instruction control sequencer with halt,
// memory wait states and a completed-instruction counter.
module cpu_ctl_seq #(
  parameter int OPW     = 3,
  parameter int WAIT_EN = 1,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch,
  input  logic            resume,
  input  logic            zero,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_rdy,
  output logic            inc_pc,
  output logic            load_acc,
  output logic            load_pc,
  output logic            rd,
  output logic            wr,
  output logic            load_ir,
  output logic            datactl_ena,
  output logic            halt,
  output logic            illegal,
  output logic [2:0]      phase,
  output logic            running,
  output logic [CNTW-1:0] instr_cnt
);
  import cpu_pkg::*;

  state_t          state;
  state_t          nxt_state;
  ctl_t            ctl_q;
  ctl_t            nxt_ctl;
  op_cls_t         cls;
  logic [2:0]      phase_q;
  logic [2:0]      nxt_ph;
  logic            run_q;
  logic            nxt_run;
  logic [CNTW-1:0] cnt_q;
  logic            bump;
  logic            stall;

  cpu_ctl_decode #(
    .OPW(OPW)
  ) u_dec (
    .opcode(opcode),
    .alu   (cls.alu),
    .sto   (cls.sto),
    .jmp   (cls.jmp),
    .skz   (cls.skz),
    .hlt   (cls.hlt),
    .ill   (cls.ill)
  );

  assign stall = (WAIT_EN != 0)
               && (ctl_q.rd || ctl_q.wr)
               && !mem_rdy;

  always_comb begin
    nxt_state = state;
    bump      = 1'b0;
    unique case (state)
      S_IDLE: if (fetch) nxt_state = S_P0;
      S_HALT: if (resume) nxt_state = S_P0;
      S_P3: begin
        nxt_state = ctl_q.halt ? S_HALT : S_P4;
        bump      = ctl_q.halt;
      end
      S_P7: begin
        nxt_state = S_P0;
        bump      = 1'b1;
      end
      S_P0, S_P1, S_P2,
      S_P4, S_P5, S_P6:
        nxt_state = state_t'(4'(state) + 4'd1);
      default: nxt_state = S_IDLE;
    endcase
    if (stall) begin
      nxt_state = state;
      bump      = 1'b0;
    end
  end

  always_comb begin
    nxt_run = (nxt_state != S_IDLE)
           && (nxt_state != S_HALT);
    nxt_ph  = nxt_run ? 3'(4'(nxt_state) - 4'd1)
                      : 3'd0;
    nxt_ctl = '0;
    // PC strobes fire once per phase; memory strobes hold.
    if (stall) begin
      nxt_ctl         = ctl_q;
      nxt_ctl.inc_pc  = 1'b0;
      nxt_ctl.load_pc = 1'b0;
      nxt_ctl.illegal = 1'b0;
    end else if (nxt_state == S_HALT) begin
      nxt_ctl.halt = 1'b1;
    end else if (nxt_run) begin
      nxt_ctl = phase_ctl(nxt_ph, cls, zero);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ctl_q   <= '0;
      phase_q <= 3'd0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= nxt_state;
      ctl_q   <= nxt_ctl;
      phase_q <= nxt_ph;
      run_q   <= nxt_run;
      if (bump) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign inc_pc      = ctl_q.inc_pc;
  assign load_acc    = ctl_q.load_acc;
  assign load_pc     = ctl_q.load_pc;
  assign rd          = ctl_q.rd;
  assign wr          = ctl_q.wr;
  assign load_ir     = ctl_q.load_ir;
  assign datactl_ena = ctl_q.datactl_ena;
  assign halt        = ctl_q.halt;
  assign illegal     = ctl_q.illegal;
  assign phase       = phase_q;
  assign running     = run_q;
  assign instr_cnt   = cnt_q;

endmodule

// File: doc/cpu_ctl_seq.md
CPU_CTL_SEQ -- requirements
Module: cpu_ctl_seq

Interface
REQ-001 SHALL have parameter OPW, default 3, meaning opcode width (>=3); base opcode in opcode[2:0].
REQ-002 SHALL have parameter WAIT_EN, default 1, meaning 1 enables mem_rdy wait-state stalling.
REQ-003 SHALL have parameter CNTW, default 16, meaning instruction counter width.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, all state on rising edge.
 rst  in  1  reset; asynchronous, active-low.
 fetch  in  1  start request, sampled in IDLE.
 resume  in  1  leave HALTED, sampled in HALTED.
 zero  in  1  accumulator-zero flag.
 opcode  in  OPW  current IR opcode.
 mem_rdy  in  1  memory ready for rd/wr.
 inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt  out  1 each  registered control strobes.
 illegal  out  1  one-cycle pulse, unknown opcode.
 phase  out  3  current phase index (0 in IDLE/HALTED).
 running  out  1  high in P0..P7.
 instr_cnt  out  CNTW  completed-instruction count.

Function
REQ-005 SHALL implement states IDLE, P0..P7, HALTED; all outputs registered, taking the value listed for a phase on the edge entering it.
REQ-006 SHALL go IDLE->P0 on the first edge with fetch=1; fetch ignored outside IDLE.
REQ-007 SHALL advance Pn->Pn+1 each cycle unless stalled (REQ-013), and P7->P0 continuously.
REQ-008 SHALL drive in P0: rd, load_ir; P1: inc_pc, rd, load_ir; P2: none.
REQ-009 SHALL drive in P3: inc_pc, plus halt if opcode=HLT(000); illegal=1 for that cycle if OPW>3 and opcode[OPW-1:3]!=0.
REQ-010 SHALL drive in P4: JMP(111) load_pc; ADD(010)/AND(011)/XOR(100)/LDA(101) rd; STO(110) datactl_ena; else none.
REQ-011 SHALL drive in P5: ALU ops load_acc, rd; SKZ(001) with zero=1 inc_pc; JMP inc_pc, load_pc; STO wr, datactl_ena; else none.
REQ-012 SHALL drive in P6: STO datactl_ena; ALU ops load_acc, rd; P7: inc_pc if SKZ and zero=1; else none.
REQ-013 SHALL, when WAIT_EN=1, hold the current phase while rd or wr is asserted and mem_rdy=0; mem_rdy ignored otherwise or when WAIT_EN=0.
REQ-014 SHALL, during stall, hold rd, wr, datactl_ena, load_ir, load_acc at their phase values and deassert inc_pc and load_pc after the first cycle of the phase (one PC update per phase).
REQ-015 SHALL treat an illegal opcode as NOP: no halt, load_pc, load_acc, wr, datactl_ena in P3..P7 (inc_pc in P3 kept).
REQ-016 SHALL go P3->HALTED when opcode=HLT; in HALTED drive halt=1, all other strobes 0, phase=0.
REQ-017 SHALL go HALTED->P0 on the first edge with resume=1; resume ignored in other states.
REQ-018 SHALL increment instr_cnt on each P7->P0 and P3->HALTED transition, wrapping modulo 2^CNTW.
REQ-019 SHALL evaluate opcode and zero combinationally at each phase edge; opcode change mid-instruction affects only later phases.

Reset
REQ-020 SHALL, on rst=0, asynchronously force state IDLE, every strobe, illegal, running, phase and instr_cnt to 0.
REQ-021 SHALL abort any instruction or stall on reset mid-operation, restarting only via fetch after rst=1.

Structure
REQ-022 SHALL place opcode constants (HLT..JMP) and state encoding in shared package cpu_pkg.
REQ-023 SHALL use one combinational sub-module cpu_ctl_decode mapping opcode to classes (alu, sto, jmp, skz, hlt, illegal).

Verification
REQ-024 Reset, fetch=1 one cycle, opcode=010, mem_rdy=1 -> P0..P7 in 8 cycles, load_acc high in P5,P6, instr_cnt=1 after P7.
REQ-025 opcode=000 -> halt=1 from P3 on, HALTED held 20 cycles, instr_cnt=1; resume pulse -> P0 next edge, halt=0.
REQ-026 opcode=110, mem_rdy=0 for 3 cycles in P5 -> P5 lasts 4 cycles, wr and datactl_ena held, no extra inc_pc.
REQ-027 opcode=001, zero=1 -> inc_pc in P1, P3, P5, P7 (4 pulses); zero=0 -> P1, P3 only.
REQ-028 OPW=4, opcode=1010 -> illegal pulse in P3, no load_acc, instr_cnt increments; CNTW=4 after 16 instructions -> instr_cnt=0.
REQ-029 rst=0 asserted mid-P5 of STO -> all outputs 0 immediately, state IDLE, no wr after rst=1 until fetch.
